pingpong_buf: RTL and testbench
===============================

PINGPONG_BUF -- requirements
Module: pingpong_buf

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 10, address width; each bank holds 2**AWIDTH words.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write strobe into current write bank.
REQ-006 SHALL have port wr_adr  input  AWIDTH  write word address.
REQ-007 SHALL have port wr_data  input  DWIDTH  write data.
REQ-008 SHALL have port wr_commit  input  1  pulse: current write bank complete, hand it to the reader.
REQ-009 SHALL have port wr_ready  output  1  current write bank is EMPTY and accepts writes and commit.
REQ-010 SHALL have port rd_en  input  1  read strobe from current read bank.
REQ-011 SHALL have port rd_adr  input  AWIDTH  read word address.
REQ-012 SHALL have port rd_release  input  1  pulse: current read bank consumed, return it to the writer.
REQ-013 SHALL have port rd_ready  output  1  current read bank is FULL and accepts reads and release.
REQ-014 SHALL have port rd_data  output  DWIDTH  registered read data.
REQ-015 SHALL have port rd_valid  output  1  rd_data updated this cycle.
REQ-016 SHALL have port full_cnt  output  2  number of FULL banks, 0..2.
REQ-017 SHALL have port wr_perr_inj  input  1  invert the stored parity bit of the current write.
REQ-018 SHALL have port rd_perr  output  1  parity mismatch on the current rd_data.

Function
REQ-019 SHALL hold two banks of 2**AWIDTH x DWIDTH words, each in state EMPTY or FULL, plus 1-bit pointers wr_sel and rd_sel.
REQ-020 SHALL drive wr_ready = (bank[wr_sel]==EMPTY) and rd_ready = (bank[rd_sel]==FULL) combinationally from state.
REQ-021 SHALL write wr_data to bank[wr_sel][wr_adr] at the clock edge when wr_en and wr_ready; wr_en without wr_ready is ignored.
REQ-022 SHALL, on wr_commit with wr_ready, set bank[wr_sel] FULL and toggle wr_sel; wr_commit without wr_ready is ignored.
REQ-023 SHALL, when wr_en and wr_commit coincide, complete the write into the bank being committed.
REQ-024 SHALL, on rd_en with rd_ready, present bank[rd_sel][rd_adr] on rd_data and assert rd_valid exactly one cycle later (latency 1).
REQ-025 SHALL, on rd_en without rd_ready, keep rd_data unchanged and deassert rd_valid the next cycle.
REQ-026 SHALL, on rd_release with rd_ready, set bank[rd_sel] EMPTY and toggle rd_sel; rd_release without rd_ready is ignored.
REQ-027 SHALL, when rd_en and rd_release coincide, return the read data from the released bank with normal latency.
REQ-028 SHALL process commit and release in the same cycle independently; they never address the same bank because a bank cannot be EMPTY and FULL at once.
REQ-029 SHALL update full_cnt at the same edge as commit/release: +1 commit only, -1 release only, unchanged when both or neither occur.
REQ-030 SHALL hold rd_data between valid reads; addresses wrap naturally within AWIDTH bits.

Reset
REQ-031 SHALL, with rst_n low at a clock edge, set both banks EMPTY, wr_sel=0, rd_sel=0, rd_data=0, rd_valid=0, rd_perr=0, full_cnt=0.
REQ-032 SHALL, during reset, ignore all writes, commits, reads and releases; memory contents are not cleared.
REQ-033 SHALL treat reset mid-operation as discarding all bank ownership; any in-flight read yields rd_valid=0 the next cycle.

Configuration
REQ-034 SHALL honour macro PPBUF_PARITY_EN: when defined, store one even-parity bit per word; wr_perr_inj inverts the stored bit; rd_perr asserts with rd_valid when recomputed parity of rd_data mismatches the stored bit.
REQ-035 SHALL, without PPBUF_PARITY_EN, store no parity bit, ignore wr_perr_inj and tie rd_perr to 0.

Verification
REQ-036 SHALL cover: reset, write 0x1234 at adr 5, commit, read adr 5 -> rd_ready=1 and full_cnt=1 after the commit; rd_data=0x1234 with rd_valid one cycle after rd_en.
REQ-037 SHALL cover: commit bank0, then write and commit bank1 without release -> full_cnt=2, wr_ready=0; a further wr_en to adr 5 leaves bank0 adr 5 unchanged.
REQ-038 SHALL cover: in one cycle, wr_commit on bank1 and rd_release on bank0 -> full_cnt unchanged at 1, wr_sel=0, rd_sel=1.
REQ-039 SHALL cover: rd_en with rd_ready=0 -> rd_valid=0 next cycle and rd_data holds its previous value.
REQ-040 SHALL cover: rst_n low mid-fill with full_cnt=1 -> next cycle full_cnt=0, wr_ready=1, rd_ready=0, rd_valid=0.
REQ-041 SHALL cover, with PPBUF_PARITY_EN: write 0x00FF with wr_perr_inj=1, commit, read -> rd_perr=1 with rd_valid; same write with wr_perr_inj=0 -> rd_perr=0.

Source files
------------

// File: rtl/pingpong_buf.sv
// pingpong_buf: two-bank ping-pong buffer between one writer and one reader.
// The writer fills the EMPTY bank selected by wr_sel and hands it over with
// wr_commit. The reader drains the FULL bank selected by rd_sel and returns
// it with rd_release. Read data has a latency of one cycle.
// Optional feature: define PPBUF_PARITY_EN to store one even-parity bit per
// word and flag mismatches on rd_perr. Without it rd_perr is tied low.
module pingpong_buf #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_adr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_adr,
  input  logic              rd_release,
  output logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        full_cnt,
  input  logic              wr_perr_inj,
  output logic              rd_perr
);

  // Both banks share one array; the top index bit selects the bank.
  localparam int DEPTH = 2 ** (AWIDTH + 1);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [1:0]        bank_full;
  logic              wr_sel;
  logic              rd_sel;
  logic [1:0]        full_cnt_q;

  logic [DWIDTH-1:0] rd_data_p1;
  logic              vld_p1;

  logic              wr_fire;
  logic              commit_fire;
  logic              release_fire;
  logic              rd_fire;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic parity_of(input logic [DWIDTH-1:0] d);
    return ^d;
  endfunction

  assign wr_ready     = ~bank_full[wr_sel];
  assign rd_ready     = bank_full[rd_sel];
  // rst_n gates every request so nothing is accepted while reset is held.
  assign wr_fire      = rst_n & wr_en & wr_ready;
  assign commit_fire  = rst_n & wr_commit & wr_ready;
  assign release_fire = rst_n & rd_release & rd_ready;
  assign rd_fire      = rst_n & rd_en & rd_ready;

  // ---- stage p0: request accepted, memory written ----

  // Memory array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_sel, wr_adr}] <= wr_data;
    end
  end

  // Bank ownership, pointers and full counter; commit and release always
  // target different banks, so both may be applied in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_full  <= 2'b00;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      full_cnt_q <= 2'd0;
    end else begin
      if (commit_fire) begin
        bank_full[wr_sel] <= 1'b1;
        wr_sel            <= ~wr_sel;
      end
      if (release_fire) begin
        bank_full[rd_sel] <= 1'b0;
        rd_sel            <= ~rd_sel;
      end
      case ({commit_fire, release_fire})
        2'b10:   full_cnt_q <= full_cnt_q + 2'd1;
        2'b01:   full_cnt_q <= full_cnt_q - 2'd1;
        default: full_cnt_q <= full_cnt_q;
      endcase
    end
  end

  // ---- stage p1: registered read data ----

  // Read register; rd_data holds its value between accepted reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_fire;
      if (rd_fire) begin
        rd_data_p1 <= mem[{rd_sel, rd_adr}];
      end
    end
  end

`ifdef PPBUF_PARITY_EN
  logic par_mem [DEPTH];
  logic perr_p1;

  // Parity array write; the injection input flips the stored bit.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      par_mem[{wr_sel, wr_adr}] <= parity_of(wr_data) ^ wr_perr_inj;
    end
  end

  // Parity check registered alongside the read data so it aligns with rd_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perr_p1 <= 1'b0;
    end else if (rd_fire) begin
      perr_p1 <= parity_of(mem[{rd_sel, rd_adr}]) ^ par_mem[{rd_sel, rd_adr}];
    end else begin
      perr_p1 <= 1'b0;
    end
  end

  assign rd_perr = perr_p1;
`else
  logic unused_perr_inj;
  logic unused_parity_fn;

  assign unused_perr_inj  = wr_perr_inj;
  assign unused_parity_fn = parity_of(wr_data);
  assign rd_perr          = 1'b0;
`endif

  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;
  assign full_cnt = full_cnt_q;

endmodule

// File: tb/tb_pingpong_buf.sv
// Self-checking bench for pingpong_buf. Expected read data and parity flags
// are queued when a read is issued and compared when rd_valid appears.
module tb_pingpong_buf;

  localparam int DWIDTH = 16;
  localparam int AWIDTH = 10;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [AWIDTH-1:0] wr_adr;
  logic [DWIDTH-1:0] wr_data;
  logic              wr_commit;
  logic              wr_ready;
  logic              rd_en;
  logic [AWIDTH-1:0] rd_adr;
  logic              rd_release;
  logic              rd_ready;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_valid;
  logic [1:0]        full_cnt;
  logic              wr_perr_inj;
  logic              rd_perr;

  int passed;
  int total;

  logic [DWIDTH-1:0] exp_data_q[$];
  logic              exp_perr_q[$];

  pingpong_buf #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_adr      (wr_adr),
    .wr_data     (wr_data),
    .wr_commit   (wr_commit),
    .wr_ready    (wr_ready),
    .rd_en       (rd_en),
    .rd_adr      (rd_adr),
    .rd_release  (rd_release),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full_cnt    (full_cnt),
    .wr_perr_inj (wr_perr_inj),
    .rd_perr     (rd_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0; wr_perr_inj = 0;
  endtask

  task automatic write_word(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d,
                            input logic inj, input logic commit);
    wr_en = 1; wr_adr = a; wr_data = d; wr_perr_inj = inj; wr_commit = commit;
    tick();
    idle();
  endtask

  task automatic commit();
    wr_commit = 1;
    tick();
    idle();
  endtask

  task automatic release_bank();
    rd_release = 1;
    tick();
    idle();
  endtask

  // Issue one read expected to be accepted, then check it against the scoreboard.
  task automatic read_check(input string name, input logic [AWIDTH-1:0] a,
                            input logic [DWIDTH-1:0] d, input logic perr, input logic rel);
    exp_data_q.push_back(d);
    exp_perr_q.push_back(perr);
    rd_en = 1; rd_adr = a; rd_release = rel;
    tick();
    idle();
    total++;
    if (rd_valid !== 1'b1) begin
      $display("FAIL %s rd_valid got %b want 1", name, rd_valid);
      void'(exp_data_q.pop_front());
      void'(exp_perr_q.pop_front());
    end else begin
      logic [DWIDTH-1:0] ed;
      logic ep;
      ed = exp_data_q.pop_front();
      ep = exp_perr_q.pop_front();
      if (rd_data !== ed) $display("FAIL %s rd_data got %h want %h", name, rd_data, ed);
      else if (rd_perr !== ep) $display("FAIL %s rd_perr got %b want %b", name, rd_perr, ep);
      else passed++;
    end
  endtask

  task automatic test_reset();
    idle();
    wr_adr = '0; wr_data = '0; rd_adr = '0;
    rst_n = 0;
    tick(); tick();
    total++;
    if ({full_cnt, wr_ready, rd_ready, rd_valid, rd_perr} !== 6'b00_1000)
      $display("FAIL reset_ctrl got cnt=%0d wrdy=%b rrdy=%b vld=%b perr=%b want 0 1 0 0 0",
               full_cnt, wr_ready, rd_ready, rd_valid, rd_perr);
    else passed++;
    total++;
    if (rd_data !== '0) $display("FAIL reset_data got %h want 0000", rd_data);
    else passed++;
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    write_word(10'd5, 16'h1234, 1'b0, 1'b0);
    commit();
    total++;
    if (rd_ready !== 1'b1 || full_cnt !== 2'd1 || wr_ready !== 1'b1)
      $display("FAIL basic_commit got rrdy=%b cnt=%0d wrdy=%b want 1 1 1", rd_ready, full_cnt, wr_ready);
    else passed++;
    read_check("basic_read", 10'd5, 16'h1234, 1'b0, 1'b0);
  endtask

  task automatic test_both_full();
    write_word(10'd6, 16'h5555, 1'b0, 1'b0);
    write_word(10'd5, 16'hBEEF, 1'b0, 1'b1);
    total++;
    if (full_cnt !== 2'd2 || wr_ready !== 1'b0)
      $display("FAIL both_full got cnt=%0d wrdy=%b want 2 0", full_cnt, wr_ready);
    else passed++;
    write_word(10'd5, 16'hDEAD, 1'b0, 1'b0);
    commit();
    total++;
    if (full_cnt !== 2'd2) $display("FAIL commit_ignored got cnt=%0d want 2", full_cnt);
    else passed++;
    read_check("bank0_kept", 10'd5, 16'h1234, 1'b0, 1'b0);
  endtask

  task automatic test_commit_release();
    release_bank();
    total++;
    if (full_cnt !== 2'd1 || wr_ready !== 1'b1 || rd_ready !== 1'b1)
      $display("FAIL release0 got cnt=%0d wrdy=%b rrdy=%b want 1 1 1", full_cnt, wr_ready, rd_ready);
    else passed++;
    read_check("bank1_adr6", 10'd6, 16'h5555, 1'b0, 1'b0);
    read_check("read_release", 10'd5, 16'hBEEF, 1'b0, 1'b1);
    total++;
    if (full_cnt !== 2'd0 || rd_ready !== 1'b0)
      $display("FAIL after_rd_release got cnt=%0d rrdy=%b want 0 0", full_cnt, rd_ready);
    else passed++;
    write_word(10'd3, 16'h0A0A, 1'b0, 1'b0);
    commit();
    write_word(10'd3, 16'h0B0B, 1'b0, 1'b0);
    wr_commit = 1; rd_release = 1;
    tick();
    idle();
    total++;
    if (full_cnt !== 2'd1 || wr_ready !== 1'b1 || rd_ready !== 1'b1)
      $display("FAIL commit_release got cnt=%0d wrdy=%b rrdy=%b want 1 1 1", full_cnt, wr_ready, rd_ready);
    else passed++;
    read_check("rd_sel_bank1", 10'd3, 16'h0B0B, 1'b0, 1'b0);
  endtask

  task automatic test_rd_not_ready();
    release_bank();
    rd_en = 1; rd_adr = 10'd3;
    tick();
    idle();
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0B0B)
      $display("FAIL rd_not_ready got vld=%b data=%h want 0 0b0b", rd_valid, rd_data);
    else passed++;
    release_bank();
    total++;
    if (full_cnt !== 2'd0) $display("FAIL release_ignored got cnt=%0d want 0", full_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    write_word(10'd7, 16'h7777, 1'b0, 1'b1);
    total++;
    if (full_cnt !== 2'd1) $display("FAIL mid_fill got cnt=%0d want 1", full_cnt);
    else passed++;
    write_word(10'd8, 16'h8888, 1'b0, 1'b0);
    rst_n = 0; rd_en = 1; rd_adr = 10'd7;
    tick();
    idle();
    total++;
    if (full_cnt !== 2'd0 || wr_ready !== 1'b1 || rd_ready !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL reset_mid got cnt=%0d wrdy=%b rrdy=%b vld=%b want 0 1 0 0",
               full_cnt, wr_ready, rd_ready, rd_valid);
    else passed++;
    wr_en = 1; wr_adr = 10'd7; wr_data = 16'hAAAA; wr_commit = 1;
    tick();
    idle();
    rst_n = 1;
    tick();
    total++;
    if (full_cnt !== 2'd0 || rd_valid !== 1'b0)
      $display("FAIL reset_ignores got cnt=%0d vld=%b want 0 0", full_cnt, rd_valid);
    else passed++;
    commit();
    read_check("mem_kept", 10'd7, 16'h7777, 1'b0, 1'b1);
  endtask

  task automatic test_parity();
    logic exp_inj;
`ifdef PPBUF_PARITY_EN
    exp_inj = 1'b1;
`else
    exp_inj = 1'b0;
`endif
    write_word(10'd1, 16'h00FF, 1'b1, 1'b0);
    write_word(10'd2, 16'h00FF, 1'b0, 1'b1);
    read_check("perr_injected", 10'd1, 16'h00FF, exp_inj, 1'b0);
    read_check("perr_clean", 10'd2, 16'h00FF, 1'b0, 1'b1);
    total++;
    if (rd_perr !== 1'b0 || full_cnt !== 2'd0)
      $display("FAIL perr_idle got perr=%b cnt=%0d want 0 0", rd_perr, full_cnt);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic();
    test_both_full();
    test_commit_release();
    test_rd_not_ready();
    test_reset_mid();
    test_parity();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
